// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank controller: command opcodes, FSM states.
// Optional build macro REG_BANK_ZERO_R0_EN is consumed by reg_bank_storage.
package reg_bank_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_MOVE = 2'b10,
      OP_SWAP = 2'b11
   } cmd_op_e;

   typedef enum logic {
      ST_IDLE,
      ST_SWAP2
   } state_e;

endpackage

// File: rtl/reg_bank_storage.sv
// Register array: async reset, one write port, three combinational read ports.
// Define REG_BANK_ZERO_R0_EN to hardwire R[0] to zero.
module reg_bank_storage #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    src_addr,
   input  logic [AW-1:0]    dst_addr,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] src_data,
   output logic [WIDTH-1:0] dst_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
`ifdef REG_BANK_ZERO_R0_EN
         // R[0] stays at its reset value of zero, so reads need no masking
         if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
         end
`else
         if (wr_en) begin
            regs[wr_addr] <= wr_data;
         end
`endif
      end
   end

   assign src_data = regs[src_addr];
   assign dst_data = regs[dst_addr];
   assign rd_data  = regs[rd_addr];

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank command controller: LOAD/MOVE/SWAP over valid/ready, one write per edge.
// Honours REG_BANK_ZERO_R0_EN through reg_bank_storage.
module reg_bank_ctrl
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [AW-1:0]    cmd_src,
   input  logic [AW-1:0]    cmd_dst,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] out,
   output logic             done,
   output logic             busy
);

   state_e           state, state_nx;
   cmd_op_e          op;
   logic [WIDTH-1:0] tmp;
   logic [AW-1:0]    swap_dst;
   logic [WIDTH-1:0] src_data, dst_data;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             tmp_we, out_we, cmpl;

   assign op        = cmd_op_e'(cmd_op);
   assign cmd_ready = (state == ST_IDLE);

   reg_bank_storage #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_storage (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .src_addr (cmd_src),
      .dst_addr (cmd_dst),
      .rd_addr  (rd_addr),
      .src_data (src_data),
      .dst_data (dst_data),
      .rd_data  (rd_data)
   );

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_addr  = cmd_dst;
      wr_data  = cmd_data;
      tmp_we   = 1'b0;
      out_we   = 1'b0;
      cmpl     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (op)
                  OP_NOP: cmpl = 1'b1;
                  OP_LOAD: begin
                     wr_en  = 1'b1;
                     out_we = 1'b1;
                     cmpl   = 1'b1;
                  end
                  OP_MOVE: begin
                     wr_en   = 1'b1;
                     wr_data = src_data;
                     out_we  = 1'b1;
                     cmpl    = 1'b1;
                  end
                  OP_SWAP: begin
                     // src==dst collapses to a single-cycle MOVE
                     if (cmd_src == cmd_dst) begin
                        wr_en   = 1'b1;
                        wr_data = src_data;
                        out_we  = 1'b1;
                        cmpl    = 1'b1;
                     end else begin
                        wr_en    = 1'b1;
                        wr_addr  = cmd_src;
                        wr_data  = dst_data;
                        tmp_we   = 1'b1;
                        state_nx = ST_SWAP2;
                     end
                  end
               endcase
            end
         end
         ST_SWAP2: begin
            wr_en    = 1'b1;
            wr_addr  = swap_dst;
            wr_data  = tmp;
            out_we   = 1'b1;
            cmpl     = 1'b1;
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         tmp      <= '0;
         swap_dst <= '0;
         out      <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= cmpl;
         busy  <= (state_nx == ST_SWAP2);
         if (tmp_we) begin
            tmp      <= src_data;
            swap_dst <= cmd_dst;
         end
         if (out_we) begin
            out <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: expected out values queued at acceptance, popped on done.
// Expectations for R0 behaviour follow REG_BANK_ZERO_R0_EN when it is defined.
module tb_reg_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [2:0]  cmd_src;
   logic [2:0]  cmd_dst;
   logic [15:0] cmd_data;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] out;
   logic        done;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic        done_at_accept;
   bit          stop_mon = 0;

   always #5 clk = ~clk;

   reg_bank_ctrl #(.WIDTH(16), .NREGS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_data  (cmd_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out       (out),
      .done      (done),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
      end
   endtask

   task automatic read_chk(input int addr, input logic [15:0] exp);
      rd_addr = 3'(addr);
      #1;
      check($sformatf("rd_data[%0d]", addr), rd_data, exp);
   endtask

   // Returns #1 after the acceptance edge; queues the expected out if exp_en.
   task automatic send(input logic [1:0] op, input int src, input int dst,
                       input logic [15:0] data, input bit exp_en, input logic [15:0] exp_out);
      bit   accepted = 0;
      logic rdy;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_src   = 3'(src);
      cmd_dst   = 3'(dst);
      cmd_data  = data;
      for (int n = 0; n < 20 && !accepted; n++) begin
         rdy            = cmd_ready;
         done_at_accept = done;
         @(posedge clk);
         if (rdy) begin
            accepted = 1;
            if (exp_en) exp_q.push_back(exp_out);
         end
         #1;
      end
      cmd_valid = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: op %0d not accepted within 20 cycles", op);
      end
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_src   = '0;
      cmd_dst   = '0;
      cmd_data  = '0;
      rd_addr   = '0;

      fork
         begin
            while (!stop_mon) begin
               @(negedge clk);
               if (done) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_done: got done=1 expected no completion, out=0x%04h", out);
                  end else begin
                     logic [15:0] e;
                     e = exp_q.pop_front();
                     if (out !== e) begin
                        errors++;
                        $display("FAIL done_out: got 0x%04h expected 0x%04h", out, e);
                     end
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", {15'd0, cmd_ready}, 16'd1);
      check("reset_done", {15'd0, done}, 16'd0);
      check("reset_busy", {15'd0, busy}, 16'd0);
      check("reset_out", out, 16'h0000);
      for (int i = 0; i < 8; i++) read_chk(i, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // LOAD then read-back
      rd_addr = 3'd3;
      send(2'b01, 0, 3, 16'hBEEF, 1, 16'hBEEF);
      read_chk(3, 16'hBEEF);
      check("load_out", out, 16'hBEEF);
      check("load_done", {15'd0, done}, 16'd1);

      // Back-to-back LOAD / MOVE
      send(2'b01, 0, 1, 16'h1234, 1, 16'h1234);
      check("b2b_ready0", {15'd0, cmd_ready}, 16'd1);
      send(2'b10, 1, 5, 16'h0000, 1, 16'h1234);
      check("b2b_ready1", {15'd0, cmd_ready}, 16'd1);
      read_chk(5, 16'h1234);

      // SWAP with valid held into a second SWAP
      send(2'b01, 0, 2, 16'h00AA, 1, 16'h00AA);
      send(2'b01, 0, 6, 16'h5500, 1, 16'h5500);
      send(2'b11, 2, 6, 16'h0000, 1, 16'h00AA);
      check("swap2_ready", {15'd0, cmd_ready}, 16'd0);
      check("swap2_busy", {15'd0, busy}, 16'd1);
      read_chk(2, 16'h5500);
      read_chk(6, 16'h5500);
      send(2'b11, 3, 5, 16'h0000, 1, 16'hBEEF);
      check("swap_accept_on_done", {15'd0, done_at_accept}, 16'd1);
      idle(2);
      check("swap_busy_clear", {15'd0, busy}, 16'd0);
      check("swap_out", out, 16'hBEEF);
      read_chk(2, 16'h5500);
      read_chk(6, 16'h00AA);
      read_chk(3, 16'h1234);
      read_chk(5, 16'hBEEF);

      // Degenerate SWAP and NOP
      send(2'b01, 0, 4, 16'h0F0F, 1, 16'h0F0F);
      send(2'b11, 4, 4, 16'h0000, 1, 16'h0F0F);
      check("dswap_ready", {15'd0, cmd_ready}, 16'd1);
      check("dswap_busy", {15'd0, busy}, 16'd0);
      read_chk(4, 16'h0F0F);
      send(2'b00, 0, 0, 16'hDEAD, 1, 16'h0F0F);
      check("nop_out", out, 16'h0F0F);

      // R0 behaviour
      send(2'b01, 0, 0, 16'hFFFF, 1, 16'hFFFF);
`ifdef REG_BANK_ZERO_R0_EN
      send(2'b10, 0, 7, 16'h0000, 1, 16'h0000);
      read_chk(0, 16'h0000);
      read_chk(7, 16'h0000);
`else
      send(2'b10, 0, 7, 16'h0000, 1, 16'hFFFF);
      read_chk(0, 16'hFFFF);
      read_chk(7, 16'hFFFF);
`endif
      idle(2);

      // Reset during SWAP2
      for (int i = 0; i < 8; i++) begin
         send(2'b01, 0, i, 16'h1111 * 16'(i + 1), 1, 16'h1111 * 16'(i + 1));
      end
      idle(2);
      send(2'b11, 1, 2, 16'h0000, 0, 16'h0000);
      check("pre_rst_busy", {15'd0, busy}, 16'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_ready", {15'd0, cmd_ready}, 16'd1);
      check("rst_mid_busy", {15'd0, busy}, 16'd0);
      check("rst_mid_done", {15'd0, done}, 16'd0);
      for (int i = 0; i < 8; i++) read_chk(i, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3);
      check("rst_out", out, 16'h0000);
      check("queue_empty", 16'(exp_q.size()), 16'd0);

      stop_mon = 1;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
